empty_ptr_storage: RTL and testbench
====================================

// Module: empty_ptr_storage
// PURPOSE
//  Free-list of data-table RAM addresses, sized for the whole table (N = 2**A_WIDTH entries).
//  - Fills itself with every address 0..N-1 after reset.
//  - Hands out the next free address to the insert stage (show-ahead, pop on ack).
//  - Takes back addresses released by the delete stage (add_empty_ptr_o/_en_o).
//  - Sits between the data-table delete/insert FSMs and the data RAM address space.
// PARAMETERS
//  A_WIDTH  TABLE_ADDR_WIDTH  width of a data-table address; storage depth N = 2**A_WIDTH
// PORTS
//  clk_i                 in   1        clock
//  rst_i                 in   1        reset, asynchronous, active-high
//  add_empty_ptr_i       in   A_WIDTH  address being returned to the free list
//  add_empty_ptr_en_i    in   1        1-cycle strobe: push add_empty_ptr_i
//  next_empty_ptr_o      out  A_WIDTH  head of free list (valid when _val_o=1)
//  next_empty_ptr_val_o  out  1        free list non-empty and init done
//  next_empty_ptr_rd_ack_i in 1        pop head this cycle
//  init_done_o           out  1        1 once initial fill is complete; stays 1 until reset
//  empty_cnt_o           out  A_WIDTH+1 number of free addresses held (0..N)
//  overflow_err_o        out  1        1-cycle pulse: push dropped (full, or during init)
//  underflow_err_o       out  1        1-cycle pulse: ack with val_o=0 ignored
// BEHAVIOUR
//  - Storage: circular buffer mem[0..N-1] of A_WIDTH-bit entries.
//    - wr_ptr, rd_ptr are A_WIDTH bits and wrap naturally N-1 -> 0.
//    - cnt is A_WIDTH+1 bits.
//  - Reset values: state=INIT_S, init_cnt=0, wr_ptr=0, rd_ptr=0, cnt=0.
//    - Outputs: next_empty_ptr_o=0, next_empty_ptr_val_o=0, init_done_o=0, empty_cnt_o=0,
//      both err=0.
//  - FSM:
//    - INIT_S: each cycle writes mem[init_cnt] <= init_cnt, then init_cnt++.
//      - When init_cnt==N-1 is written: next state READY_S, wr_ptr=0 (wrapped), cnt=N.
//      - Init takes exactly N clock edges after rst_i deasserts.
//    - READY_S: terminal until reset. init_done_o=1.
//  - Read is show-ahead:
//    - next_empty_ptr_o = mem[rd_ptr] (async read / register array).
//    - next_empty_ptr_val_o = (state==READY_S) && (cnt!=0).
//  - Pop: ack && val_o -> rd_ptr++, cnt-- on next edge.
//    - ack while val_o=0 (empty or INIT_S): no state change, underflow_err_o=1 next cycle.
//  - Push: en && READY_S && cnt<N -> mem[wr_ptr] <= add_empty_ptr_i, wr_ptr++, cnt++.
//    - en while cnt==N or in INIT_S: entry dropped, overflow_err_o=1 next cycle.
//  - Simultaneous push and valid pop: both performed, cnt unchanged.
//    - When cnt==0 no pop is possible (val_o=0); push proceeds and underflow flags if acked.
//    - When cnt==N push is dropped even if a pop occurs in the same cycle (full checked
//      before the pop).
//  - Latency: a pushed address is visible at next_empty_ptr_o on the cycle after the push
//    edge if it lands at rd_ptr (list was empty); otherwise in FIFO order.
//  - No duplicate detection: double-free of an address is not checked here; only the full
//    overflow is flagged.
//  - empty_cnt_o = cnt, registered.
//  - Reset asserted mid-operation (including mid-init): all state returns to reset values;
//    init restarts from 0 on deassert. mem contents are not reset; they are overwritten
//    by init.
//  - err outputs are registered single-cycle pulses, independent of each other.
// TESTING (A_WIDTH=3, N=8)
//  - Reset release -> val_o=0 for 8 cycles.
//    - Then init_done_o=1, val_o=1, ptr_o=0, empty_cnt_o=8.
//  - Hold ack=1 for 8 cycles after init -> ptr_o sequence 0,1,..,7.
//    - Then val_o=0, empty_cnt_o=0; a 9th ack -> underflow_err_o pulse, cnt stays 0.
//  - Empty list, push 5 -> next cycle val_o=1, ptr_o=5, cnt=1.
//    - Push 2 with simultaneous ack -> ptr_o=2, cnt=1.
//  - Full list (cnt=8), push 3 -> overflow_err_o pulse, cnt=8, ptr_o order unchanged.
//    - Push 3 plus ack at cnt=8 -> pop done, push dropped, cnt=7, overflow pulse.
//  - Pop 0..7, push 6,1,4 in order -> output order 6,1,4; rd_ptr/wr_ptr wrap past 7 correctly.
//  - Assert rst_i at init cycle 4, release -> full 8-cycle init restarts; ptr_o=0 after.
//    - Push during INIT_S -> overflow pulse, entry dropped, cnt=8 at init end.

Source files
------------

// File: rtl/empty_ptr_storage_if.sv
// Free-list handshake bundle: push of returned addresses, show-ahead pop, status and error flags.
interface empty_ptr_storage_if #(
  parameter int unsigned A_WIDTH = 3
);
  logic [A_WIDTH-1:0] add_empty_ptr_i;
  logic               add_empty_ptr_en_i;
  logic [A_WIDTH-1:0] next_empty_ptr_o;
  logic               next_empty_ptr_val_o;
  logic               next_empty_ptr_rd_ack_i;
  logic               init_done_o;
  logic [A_WIDTH:0]   empty_cnt_o;
  logic               overflow_err_o;
  logic               underflow_err_o;

  modport master (
    output add_empty_ptr_i,
    output add_empty_ptr_en_i,
    output next_empty_ptr_rd_ack_i,
    input  next_empty_ptr_o,
    input  next_empty_ptr_val_o,
    input  init_done_o,
    input  empty_cnt_o,
    input  overflow_err_o,
    input  underflow_err_o
  );

  modport slave (
    input  add_empty_ptr_i,
    input  add_empty_ptr_en_i,
    input  next_empty_ptr_rd_ack_i,
    output next_empty_ptr_o,
    output next_empty_ptr_val_o,
    output init_done_o,
    output empty_cnt_o,
    output overflow_err_o,
    output underflow_err_o
  );
endinterface

// File: rtl/empty_ptr_storage.sv
// Free list of data-table addresses: self-fills with 0..N-1 after reset, then serves
// show-ahead pops to the insert stage and accepts addresses returned by the delete stage.
module empty_ptr_storage #(
  parameter int unsigned A_WIDTH = 3
) (
  input logic                clk_i,
  input logic                rst_i,
  empty_ptr_storage_if.slave bus
);
  localparam int unsigned N = 2 ** A_WIDTH;
  localparam logic [A_WIDTH-1:0] LastAddr = {A_WIDTH{1'b1}};
  localparam logic [A_WIDTH-1:0] PtrOne   = A_WIDTH'(1);
  localparam logic [A_WIDTH:0]   CntOne   = (A_WIDTH + 1)'(1);
  localparam logic [A_WIDTH:0]   CntFull  = (A_WIDTH + 1)'(N);

  typedef enum logic {StInit, StReady} state_e;

  state_e             r_state, w_state_nxt;
  logic [A_WIDTH-1:0] r_init_cnt, w_init_cnt_nxt;
  logic [A_WIDTH-1:0] r_wr_ptr, w_wr_ptr_nxt;
  logic [A_WIDTH-1:0] r_rd_ptr, w_rd_ptr_nxt;
  logic [A_WIDTH:0]   r_cnt, w_cnt_nxt;
  logic               r_ovf, w_ovf_nxt;
  logic               r_unf, w_unf_nxt;
  logic [A_WIDTH-1:0] r_mem [N];

  logic               w_val;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_mem_we;
  logic [A_WIDTH-1:0] w_mem_waddr;
  logic [A_WIDTH-1:0] w_mem_wdata;

  assign w_val  = (r_state == StReady) && (r_cnt != '0);
  assign w_full = (r_cnt == CntFull);

  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_cnt_nxt      = r_cnt;
    w_push         = 1'b0;
    w_pop          = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_waddr    = r_wr_ptr;
    w_mem_wdata    = bus.add_empty_ptr_i;
    case (r_state)
      StInit: begin
        w_mem_we       = 1'b1;
        w_mem_waddr    = r_init_cnt;
        w_mem_wdata    = r_init_cnt;
        w_init_cnt_nxt = r_init_cnt + PtrOne;
        if (r_init_cnt == LastAddr) begin
          w_state_nxt  = StReady;
          w_wr_ptr_nxt = '0;
          w_cnt_nxt    = CntFull;
        end
      end
      StReady: begin
        // Fullness is judged before any same-cycle pop frees a slot.
        w_push   = bus.add_empty_ptr_en_i && !w_full;
        w_pop    = bus.next_empty_ptr_rd_ack_i && w_val;
        w_mem_we = w_push;
        if (w_push) w_wr_ptr_nxt = r_wr_ptr + PtrOne;
        if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + PtrOne;
        if (w_push && !w_pop)      w_cnt_nxt = r_cnt + CntOne;
        else if (w_pop && !w_push) w_cnt_nxt = r_cnt - CntOne;
      end
      default: w_state_nxt = StInit;
    endcase
    w_ovf_nxt = bus.add_empty_ptr_en_i && !w_push;
    w_unf_nxt = bus.next_empty_ptr_rd_ack_i && !w_val;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= StInit;
      r_init_cnt <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ovf      <= w_ovf_nxt;
      r_unf      <= w_unf_nxt;
    end
  end

  // Storage is not reset; the init sweep overwrites every entry.
  always_ff @(posedge clk_i) begin
    if (w_mem_we && !rst_i) r_mem[w_mem_waddr] <= w_mem_wdata;
  end

  assign bus.next_empty_ptr_o     = w_val ? r_mem[r_rd_ptr] : '0;
  assign bus.next_empty_ptr_val_o = w_val;
  assign bus.init_done_o          = (r_state == StReady);
  assign bus.empty_cnt_o          = r_cnt;
  assign bus.overflow_err_o       = r_ovf;
  assign bus.underflow_err_o      = r_unf;
endmodule

// File: tb/tb_empty_ptr_storage.sv
// Bench for empty_ptr_storage (A_WIDTH=3): directed scenarios then randomized traffic,
// checked every cycle against a queue-based free-list model.
module tb_empty_ptr_storage;
  localparam int unsigned AW = 3;
  localparam int unsigned N  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  empty_ptr_storage_if #(.A_WIDTH(AW)) bus ();

  empty_ptr_storage #(.A_WIDTH(AW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model
  int q[$];
  bit m_ready;
  int m_init_cycles;
  bit m_ovf;
  bit m_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    bit ev;
    ev = m_ready && (q.size() != 0);
    chk({ctx, ".val"},   32'(bus.next_empty_ptr_val_o), 32'(ev));
    chk({ctx, ".ptr"},   32'(bus.next_empty_ptr_o), ev ? 32'(q[0]) : 32'd0);
    chk({ctx, ".done"},  32'(bus.init_done_o), 32'(m_ready));
    chk({ctx, ".cnt"},   32'(bus.empty_cnt_o), 32'(q.size()));
    chk({ctx, ".ovf"},   32'(bus.overflow_err_o), 32'(m_ovf));
    chk({ctx, ".unf"},   32'(bus.underflow_err_o), 32'(m_unf));
  endtask

  task automatic model_reset();
    q.delete();
    m_ready       = 1'b0;
    m_init_cycles = 0;
    m_ovf         = 1'b0;
    m_unf         = 1'b0;
  endtask

  // One clock: drive inputs, advance the model on the edge, check just after it.
  task automatic step(input string ctx, input bit en, input int data, input bit ack);
    bit full, val;
    bus.add_empty_ptr_en_i      = en;
    bus.add_empty_ptr_i         = AW'(data);
    bus.next_empty_ptr_rd_ack_i = ack;
    @(posedge clk);
    if (!m_ready) begin
      m_ovf = en;
      m_unf = ack;
      m_init_cycles++;
      if (m_init_cycles == N) begin
        m_ready = 1'b1;
        for (int i = 0; i < N; i++) q.push_back(i);
      end
    end else begin
      val  = q.size() != 0;
      full = q.size() == N;
      m_ovf = en && full;
      m_unf = ack && !val;
      if (ack && val) void'(q.pop_front());
      if (en && !full) q.push_back(data);
    end
    #1;
    check_all(ctx);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_all("rst");
    repeat (2) @(posedge clk);
    #1;
    check_all("rst_hold");
    rst = 1'b0;
  endtask

  initial begin
    bus.add_empty_ptr_en_i      = 1'b0;
    bus.add_empty_ptr_i         = '0;
    bus.next_empty_ptr_rd_ack_i = 1'b0;
    model_reset();

    apply_reset();
    repeat (N) step("init", 1'b0, 0, 1'b0);
    step("ready_idle", 1'b0, 0, 1'b0);

    // Drain all 8, then one ack too many.
    repeat (N) step("drain", 1'b0, 0, 1'b1);
    step("underflow", 1'b0, 0, 1'b1);
    step("unf_clear", 1'b0, 0, 1'b0);

    // Empty list: push 5, then push 2 with ack.
    step("push5", 1'b1, 5, 1'b0);
    step("push2_ack", 1'b1, 2, 1'b1);
    step("pop2", 1'b0, 0, 1'b1);

    // Refill to full, then overflow alone and overflow with pop.
    for (int i = 0; i < N; i++) step("refill", 1'b1, (i * 3) % N, 1'b0);
    step("ovf_full", 1'b1, 3, 1'b0);
    step("ovf_pop", 1'b1, 3, 1'b1);
    step("ovf_clear", 1'b0, 0, 1'b0);

    // Drain and push 6,1,4 to exercise pointer wrap.
    repeat (N) step("drain2", 1'b0, 0, 1'b1);
    step("p6", 1'b1, 6, 1'b0);
    step("p1", 1'b1, 1, 1'b0);
    step("p4", 1'b1, 4, 1'b0);
    repeat (3) step("pop_wrap", 1'b0, 0, 1'b1);

    // Reset during init, with a push and an ack issued while initialising.
    apply_reset();
    repeat (4) step("init_a", 1'b0, 0, 1'b0);
    rst = 1'b1;
    model_reset();
    #1;
    check_all("mid_init_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("init_push", 1'b1, 7, 1'b0);
    step("init_ack", 1'b0, 0, 1'b1);
    repeat (N - 2) step("init_b", 1'b0, 0, 1'b0);
    step("post_init", 1'b0, 0, 1'b0);

    // Randomized traffic, alternating push-heavy and pop-heavy phases.
    for (int ph = 0; ph < 8; ph++) begin
      int p_en, p_ack;
      p_en  = (ph % 2 == 0) ? 80 : 25;
      p_ack = (ph % 2 == 0) ? 25 : 80;
      for (int k = 0; k < 40; k++) begin
        step("rand",
             bit'($urandom_range(99) < p_en),
             int'($urandom_range(N - 1)),
             bit'($urandom_range(99) < p_ack));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
